// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: state encodings, default widths
// and the wait-counter width.
package mem_responder_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int CNT_W      = 4;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/mem_responder_if.sv
// Controller-to-memory request bus. Optional collision flag under MEM_RESP_COLLISION_EN.
interface mem_responder_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   // Handshake: a request starts on a rising edge of req_strobe (sampled on clock),
   // with addr/wdata/write sampled on that same edge; completion is the one-cycle
   // ready pulse, and busy covers capture through the ready cycle inclusive.
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              req_write;
   logic              req_strobe;
   logic [DATA_W-1:0] rdata;
   logic              ready;
   logic              busy;
`ifdef MEM_RESP_COLLISION_EN
   logic              err;

   modport master (output req_addr, req_wdata, req_write, req_strobe,
                   input  rdata, ready, busy, err);
   modport slave  (input  req_addr, req_wdata, req_write, req_strobe,
                   output rdata, ready, busy, err);
`else
   modport master (output req_addr, req_wdata, req_write, req_strobe,
                   input  rdata, ready, busy);
   modport slave  (input  req_addr, req_wdata, req_write, req_strobe,
                   output rdata, ready, busy);
`endif
endinterface

// File: rtl/mem_responder_strobe_edge.sv
// Registered rising-edge detector; the history register's reset value is a
// parameter so a level held through reset can be masked.
module strobe_edge #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic d_i,
   output logic rise_o
);
   logic hist_q;

   always_ff @(posedge clock) begin
      if (reset) hist_q <= RESET_VAL;
      else       hist_q <= d_i;
   end

   assign rise_o = d_i & ~hist_q;

endmodule

// File: rtl/mem_responder.sv
// Strobe-driven memory responder with programmable wait states and a ready pulse.
// Define MEM_RESP_COLLISION_EN to add the sticky collision flag on the bus.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WAIT_STATES = 2
) (
   input  logic            clock,
   input  logic            reset,
   mem_responder_if.slave  bus,
   output state_t          state_o
);
   localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);

   logic              rise;
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   strobe_edge #(.RESET_VAL(1'b1)) u_edge (
      .clock  (clock),
      .reset  (reset),
      .d_i    (bus.req_strobe),
      .rise_o (rise)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      rdata_d = rdata_q;
      ready_d = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         // DONE accepts a new strobe exactly like IDLE, allowing back-to-back requests.
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            if (rise) begin
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               write_d = bus.req_write;
               busy_d  = 1'b1;
               cnt_d   = WS;
               state_d = (WS == '0) ? ST_ACCESS : ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= CNT_W'(1)) state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (!write_q) rdata_d = mem_q[addr_q];
            ready_d = 1'b1;
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   // Storage survives reset; a write aborted by reset before its ACCESS edge never lands.
   always_ff @(posedge clock) begin
      if (!reset && state_q == ST_ACCESS && write_q) mem_q[addr_q] <= wdata_q;
   end

`ifdef MEM_RESP_COLLISION_EN
   logic err_q;

   always_ff @(posedge clock) begin
      if (reset) err_q <= 1'b0;
      else if (rise && (state_q == ST_WAIT || state_q == ST_ACCESS)) err_q <= 1'b1;
   end

   assign bus.err = err_q;
`endif

   assign bus.rdata = rdata_q;
   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign state_o   = state_q;

endmodule
